// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulates the 8-channel serial ADC for controller loopback testing.
// Define ADC_RESP_RAMP_EN to replace CH0..CH7 with a per-frame ramp pattern.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [11:0] CH0,
    input  logic [11:0] CH1,
    input  logic [11:0] CH2,
    input  logic [11:0] CH3,
    input  logic [11:0] CH4,
    input  logic [11:0] CH5,
    input  logic [11:0] CH6,
    input  logic [11:0] CH7,
    input  logic        ADC_SCLK,
    input  logic        ADC_CS_N,
    input  logic        ADC_DIN,
    output logic        ADC_DOUT,
    output logic [5:0]  LAST_CFG,
    output logic        FRAME_DONE,
    output logic        FRAME_ERR
);
    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_s, cs_s, din_s;
    logic        sclk_d, cs_d, state;
    logic [3:0]  rise_cnt, fall_cnt;
    logic [5:0]  cfg;
    logic [11:0] tx, pending, sel, result;
    logic [2:0]  idx;
    logic [11:0] ch [8];

    wire sclk_now  = sclk_s[SYNC_STAGES-1];
    wire cs_now    = cs_s[SYNC_STAGES-1];
    wire din_now   = din_s[SYNC_STAGES-1];
    wire sclk_rise = sclk_now & ~sclk_d;
    wire sclk_fall = ~sclk_now & sclk_d;
    wire cs_rise   = cs_now & ~cs_d;
    wire cs_fall   = ~cs_now & cs_d;

    assign ch = '{CH0, CH1, CH2, CH3, CH4, CH5, CH6, CH7};
    assign idx = {cfg[3], cfg[2], cfg[4]};
    assign ADC_DOUT = tx[11];

`ifdef ADC_RESP_RAMP_EN
    logic [11:0] frame_cnt;
    logic unused_ch;
    assign unused_ch = ^{CH0, CH1, CH2, CH3, CH4, CH5, CH6, CH7};
    assign sel = frame_cnt + {1'b0, idx, 8'h00};
`else
    assign sel = ch[idx];
`endif
    assign result = (cfg[5] ? sel : 12'h800) ^ (cfg[1] ? 12'h000 : 12'h800);

    // CS_N sync resets to asserted so a reset mid-frame never produces a spurious frame start.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            sclk_s     <= '0;
            cs_s       <= '0;
            din_s      <= '0;
            sclk_d     <= 1'b0;
            cs_d       <= 1'b0;
            state      <= IDLE;
            rise_cnt   <= 4'd0;
            fall_cnt   <= 4'd0;
            cfg        <= 6'd0;
            tx         <= 12'd0;
            pending    <= 12'd0;
            LAST_CFG   <= 6'b100010;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
`ifdef ADC_RESP_RAMP_EN
            frame_cnt  <= 12'd0;
`endif
        end else begin
            sclk_s     <= {sclk_s[SYNC_STAGES-2:0], ADC_SCLK};
            cs_s       <= {cs_s[SYNC_STAGES-2:0], ADC_CS_N};
            din_s      <= {din_s[SYNC_STAGES-2:0], ADC_DIN};
            sclk_d     <= sclk_now;
            cs_d       <= cs_now;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    state    <= SHIFT;
                    tx       <= pending;
                    rise_cnt <= 4'd0;
                    fall_cnt <= 4'd0;
                    cfg      <= 6'd0;
                end
            end else if (cs_rise) begin
                state      <= IDLE;
                tx         <= 12'd0;
                FRAME_DONE <= 1'b1;
                FRAME_ERR  <= fall_cnt < 4'd12;
                if (rise_cnt >= 4'd6) begin
                    LAST_CFG <= cfg;
                    pending  <= result;
                end
`ifdef ADC_RESP_RAMP_EN
                frame_cnt  <= frame_cnt + 12'd1;
`endif
            end else begin
                if (sclk_rise) begin
                    if (rise_cnt < 4'd6) cfg <= {cfg[4:0], din_now};
                    if (rise_cnt != 4'd15) rise_cnt <= rise_cnt + 4'd1;
                end
                if (sclk_fall) begin
                    tx <= {tx[10:0], 1'b0};
                    if (fall_cnt != 4'd15) fall_cnt <= fall_cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed and random frames against a frame-level reference model.
module tb_adc_spi_responder;
    localparam int H = 6;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        ADC_SCLK = 1'b0, ADC_CS_N = 1'b1, ADC_DIN = 1'b0;
    logic        ADC_DOUT, FRAME_DONE, FRAME_ERR;
    logic [5:0]  LAST_CFG;
    logic [11:0] ch [8];

    int n_assert = 0, n_fail = 0;
    int done_cnt = 0, err_cnt = 0;

    logic [11:0] m_pend = 12'h000;
    logic [5:0]  m_cfg = 6'b100010;
    int          m_fc = 0;

    adc_spi_responder #(.SYNC_STAGES(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
        .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
        .ADC_SCLK(ADC_SCLK), .ADC_CS_N(ADC_CS_N), .ADC_DIN(ADC_DIN),
        .ADC_DOUT(ADC_DOUT), .LAST_CFG(LAST_CFG),
        .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) begin
        if (FRAME_DONE) done_cnt <= done_cnt + 1;
        if (FRAME_ERR) err_cnt <= err_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Converter behaviour: channel {S1,S0,O/S}, differential reads mid-scale, bipolar flips the MSB.
    function automatic logic [11:0] model_result(input logic [5:0] c);
        int idx, v;
        idx = int'(c[3]) * 4 + int'(c[2]) * 2 + int'(c[4]);
`ifdef ADC_RESP_RAMP_EN
        v = (m_fc + idx * 256) % 4096;
`else
        v = int'(ch[idx]);
`endif
        if (!c[5]) v = 'h800;
        if (!c[1]) v = v ^ 'h800;
        return 12'(v);
    endfunction

    task automatic pulse(input logic d, output logic q);
        ADC_DIN = d;
        cyc(2);
        ADC_SCLK = 1'b1;
        cyc(3);
        q = ADC_DOUT;
        cyc(H - 3);
        ADC_SCLK = 1'b0;
        cyc(H);
    endtask

    task automatic run_frame(input string tag, input logic [5:0] c, input int n);
        logic [15:0] rd, ex;
        logic q;
        int bd, be;
        bd = done_cnt;
        be = err_cnt;
        rd = '0;
        ex = '0;
        ADC_CS_N = 1'b0;
        cyc(H);
        for (int i = 0; i < n; i++) begin
            pulse(i < 6 ? c[5 - i] : 1'b0, q);
            rd = {rd[14:0], q};
            ex = {ex[14:0], i < 12 ? m_pend[11 - i] : 1'b0};
        end
        ADC_CS_N = 1'b1;
        cyc(12);
        check({tag, "_read"}, rd, ex);
        check({tag, "_done"}, 16'(done_cnt - bd), 16'd1);
        check({tag, "_err"}, 16'(err_cnt - be), 16'(n < 12));
        if (n >= 6) begin
            m_cfg = c;
            m_pend = model_result(c);
        end
        m_fc = (m_fc + 1) % 4096;
        check({tag, "_cfg"}, 16'(LAST_CFG), 16'(m_cfg));
    endtask

    initial begin
        logic q;
        int bd;
        for (int i = 0; i < 8; i++) ch[i] = 12'h000;
        cyc(3);
        check("rst_dout", 16'(ADC_DOUT), 16'd0);
        check("rst_done", 16'(FRAME_DONE), 16'd0);
        check("rst_err", 16'(FRAME_ERR), 16'd0);
        check("rst_cfg", 16'(LAST_CFG), 16'(6'b100010));
        RESET = 1'b1;
        cyc(10);

        ch[0] = 12'hABC;
        run_frame("first", 6'b100010, 12);
        run_frame("second", 6'b100010, 12);

        ch[1] = 12'h111;
        ch[6] = 12'h666;
        run_frame("map_a", 6'b110010, 12);
        run_frame("map_b", 6'b101110, 12);
        run_frame("map_c", 6'b100010, 12);

        ch[0] = 12'h100;
        run_frame("bip_a", 6'b100000, 12);
        run_frame("diff_a", 6'b000010, 12);
        run_frame("diff_b", 6'b100010, 12);

        run_frame("short", 6'b110010, 4);
        run_frame("after_short", 6'b100010, 12);
        run_frame("long", 6'b101110, 16);
        run_frame("after_long", 6'b100010, 12);

        repeat (20) begin
            for (int i = 0; i < 8; i++) ch[i] = 12'($urandom_range(0, 4095));
            run_frame("rand", 6'($urandom_range(0, 63)), int'($urandom_range(4, 16)));
        end

        ch[0] = 12'hFFF;
        run_frame("pre_rst", 6'b100010, 12);
        run_frame("pre_rst2", 6'b100010, 12);
        bd = done_cnt;
        ADC_CS_N = 1'b0;
        cyc(H);
        for (int i = 0; i < 5; i++) pulse(6'b100010 >> (5 - i), q);
        check("mid_dout_before", 16'(ADC_DOUT), 16'(m_pend[6]));
        RESET = 1'b0;
        cyc(1);
        check("mid_dout_after", 16'(ADC_DOUT), 16'd0);
        cyc(2);
        RESET = 1'b1;
        m_pend = 12'h000;
        m_cfg = 6'b100010;
        m_fc = 0;
        cyc(H);
        ADC_CS_N = 1'b1;
        cyc(12);
        check("mid_no_done", 16'(done_cnt - bd), 16'd0);
        check("mid_cfg", 16'(LAST_CFG), 16'(6'b100010));
        run_frame("post_rst", 6'b100010, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
